// File: rtl/hpdcache_mem_read_mux_rr.sv
// N-channel round-robin read-request mux with per-channel outstanding limits and ID-based response routing.
// Optional grant statistics are enabled by defining HPDCACHE_MEM_RD_MUX_STATS_EN.
module hpdcache_mem_read_mux_rr #(
    parameter int N         = 4,
    parameter int ADDR_W    = 56,
    parameter int ID_W      = 6,
    parameter int DATA_W    = 512,
    parameter int MAX_OUTST = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N-1:0]             req_valid_i,
    output logic [N-1:0]             req_ready_o,
    input  logic [N*ADDR_W-1:0]      req_addr_i,
    input  logic [N*ID_W-1:0]        req_id_i,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [ADDR_W-1:0]        mem_req_addr_o,
    output logic [ID_W+$clog2(N)-1:0] mem_req_id_o,
    input  logic                     mem_resp_valid_i,
    output logic                     mem_resp_ready_o,
    input  logic [ID_W+$clog2(N)-1:0] mem_resp_id_i,
    input  logic [DATA_W-1:0]        mem_resp_data_i,
    input  logic                     mem_resp_last_i,
    input  logic                     mem_resp_error_i,
    output logic [N-1:0]             rsp_valid_o,
    input  logic [N-1:0]             rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_last_o,
    output logic                     rsp_error_o,
    output logic                     unroutable_o,
    output logic [N*32-1:0]          stat_grants_o
);

    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [SEL_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  outst [N];
    logic [N-1:0]      eligible;
    logic [N-1:0]      grant;
    logic              grant_any;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic [ADDR_W-1:0] grant_addr;
    logic [ID_W-1:0]   grant_id;
    logic [SEL_W-1:0]  resp_sel;
    logic              resp_routable;
    logic [N-1:0]      resp_done;

    assign load = !mem_req_valid_o || mem_req_ready_i;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            eligible[k] = req_valid_i[k] && (outst[k] < CNT_W'(MAX_OUTST));
        end
    end

    // Round-robin search: first eligible channel at or after the pointer, wrapping at N.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = SEL_W'(idx);
            end
        end
        grant = '0;
        if (load && grant_any) grant[grant_idx] = 1'b1;
    end

    assign req_ready_o = grant;
    assign grant_addr  = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
    assign grant_id    = req_id_i[grant_idx*ID_W +: ID_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_id_o    <= '0;
            rr_ptr          <= '0;
        end else if (load) begin
            mem_req_valid_o <= grant_any;
            if (grant_any) begin
                mem_req_addr_o <= grant_addr;
                mem_req_id_o   <= {grant_idx, grant_id};
                rr_ptr         <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Response routing is purely combinational; unknown selects are sunk.
    assign resp_sel = mem_resp_id_i[ID_W +: SEL_W];

    always_comb begin
        rsp_valid_o      = '0;
        mem_resp_ready_o = 1'b1;
        resp_routable    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (resp_sel == SEL_W'(k)) begin
                rsp_valid_o[k]   = mem_resp_valid_i;
                mem_resp_ready_o = rsp_ready_i[k];
                resp_routable    = 1'b1;
            end
        end
        resp_done = rsp_valid_o & {N{mem_resp_ready_o && mem_resp_last_i}};
    end

    assign rsp_id_o    = mem_resp_id_i[ID_W-1:0];
    assign rsp_data_o  = mem_resp_data_i;
    assign rsp_last_o  = mem_resp_last_i;
    assign rsp_error_o = mem_resp_error_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) outst[k] <= '0;
            unroutable_o <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (grant[k] && !resp_done[k]) begin
                    outst[k] <= outst[k] + 1'b1;
                end else if (!grant[k] && resp_done[k] && outst[k] != '0) begin
                    outst[k] <= outst[k] - 1'b1;
                end
            end
            if (mem_resp_valid_i && !resp_routable) unroutable_o <= 1'b1;
        end
    end

`ifdef HPDCACHE_MEM_RD_MUX_STATS_EN
    logic [31:0] stat_cnt [N];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) stat_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (grant[k]) stat_cnt[k] <= stat_cnt[k] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) stat_grants_o[k*32 +: 32] = stat_cnt[k];
    end
`else
    assign stat_grants_o = '0;
`endif

endmodule

// File: tb/tb_hpdcache_mem_read_mux_rr.sv
// Bench for hpdcache_mem_read_mux_rr: N=4 instance checked every cycle against a queue-free behavioural model,
// plus an N=3 instance exercising the unroutable-select path.
module tb_hpdcache_mem_read_mux_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int IW = 6;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0]  req_addr;
    logic [N*IW-1:0]  req_id;
    logic             mem_req_valid, mem_req_ready;
    logic [AW-1:0]    mem_req_addr;
    logic [IW+SW-1:0] mem_req_id, mem_resp_id;
    logic             mem_resp_valid, mem_resp_ready, mem_resp_last, mem_resp_error;
    logic [DW-1:0]    mem_resp_data, rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             rsp_last, rsp_error, unroutable;
    logic [N*32-1:0]  stat_grants;

    logic [2:0]       req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [3*AW-1:0]  req_addr3;
    logic [3*IW-1:0]  req_id3;
    logic             mem_req_valid3, mem_req_ready3;
    logic [AW-1:0]    mem_req_addr3;
    logic [IW+SW-1:0] mem_req_id3, mem_resp_id3;
    logic             mem_resp_valid3, mem_resp_ready3;
    logic [DW-1:0]    rsp_data3;
    logic [IW-1:0]    rsp_id3;
    logic             rsp_last3, rsp_error3, unroutable3;
    logic [3*32-1:0]  stat_grants3;

    hpdcache_mem_read_mux_rr #(.N(N), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_id_i(req_id),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_id_o(mem_req_id),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
        .mem_resp_id_i(mem_resp_id), .mem_resp_data_i(mem_resp_data),
        .mem_resp_last_i(mem_resp_last), .mem_resp_error_i(mem_resp_error),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .rsp_error_o(rsp_error),
        .unroutable_o(unroutable), .stat_grants_o(stat_grants)
    );

    hpdcache_mem_read_mux_rr #(.N(3), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MAX_OUTST(MO)) u3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_addr_i(req_addr3), .req_id_i(req_id3),
        .mem_req_valid_o(mem_req_valid3), .mem_req_ready_i(mem_req_ready3),
        .mem_req_addr_o(mem_req_addr3), .mem_req_id_o(mem_req_id3),
        .mem_resp_valid_i(mem_resp_valid3), .mem_resp_ready_o(mem_resp_ready3),
        .mem_resp_id_i(mem_resp_id3), .mem_resp_data_i(mem_resp_data),
        .mem_resp_last_i(mem_resp_last), .mem_resp_error_i(mem_resp_error),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_id_o(rsp_id3),
        .rsp_data_o(rsp_data3), .rsp_last_o(rsp_last3), .rsp_error_o(rsp_error3),
        .unroutable_o(unroutable3), .stat_grants_o(stat_grants3)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model of the N=4 instance
    int               m_ptr = 0;
    int               m_outst [N] = '{default: 0};
    int               m_grants[N] = '{default: 0};
    bit               m_valid = 1'b0;
    logic [AW-1:0]    m_addr = '0;
    logic [IW+SW-1:0] m_id = '0;
    bit               m_unr = 1'b0;

    function automatic int pick();
        if (m_valid && !mem_req_ready) return -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req_valid[k] && m_outst[k] < MO) return k;
        end
        return -1;
    endfunction

    function automatic int resp_sel();
        return int'(mem_resp_id) >> IW;
    endfunction

    function automatic bit resp_accept();
        int s;
        s = resp_sel();
        return (s < N) ? rsp_ready[s] : 1'b1;
    endfunction

    always @(posedge clk) begin : model_update
        int g;
        int s;
        bit acc;
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_addr = '0; m_id = '0; m_unr = 0;
            for (int k = 0; k < N; k++) begin m_outst[k] = 0; m_grants[k] = 0; end
        end else begin
            g   = pick();
            s   = resp_sel();
            acc = resp_accept();
            if (mem_resp_valid && acc && mem_resp_last && s < N && m_outst[s] > 0) m_outst[s]--;
            if (mem_resp_valid && s >= N) m_unr = 1;
            if (g >= 0) begin
                m_valid = 1;
                m_addr  = req_addr[g*AW +: AW];
                m_id    = {SW'(g), req_id[g*IW +: IW]};
                m_ptr   = (g + 1) % N;
                m_outst[g]++;
                m_grants[g]++;
            end else if (!m_valid || mem_req_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        int s;
        g = pick();
        s = resp_sel();
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'd0);
        chk("mem_req_valid", 64'(mem_req_valid), 64'(m_valid));
        if (m_valid) begin
            chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
            chk("mem_req_id", 64'(mem_req_id), 64'(m_id));
        end
        chk("rsp_valid", 64'(rsp_valid), (mem_resp_valid && s < N) ? 64'(1) << s : 64'd0);
        chk("mem_resp_ready", 64'(mem_resp_ready), 64'(resp_accept()));
        if (mem_resp_valid) begin
            chk("rsp_id", 64'(rsp_id), 64'(mem_resp_id[IW-1:0]));
            chk("rsp_data", 64'(rsp_data), 64'(mem_resp_data));
            chk("rsp_last_err", 64'({rsp_last, rsp_error}), 64'({mem_resp_last, mem_resp_error}));
        end
        chk("unroutable", 64'(unroutable), 64'(m_unr));
        for (int k = 0; k < N; k++) begin
`ifdef HPDCACHE_MEM_RD_MUX_STATS_EN
            chk("stat_grants", 64'(stat_grants[k*32 +: 32]), 64'(m_grants[k]));
`else
            chk("stat_grants_zero", 64'(stat_grants[k*32 +: 32]), 64'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = AW'(32'hA000 + k*32'h100 + cyc);
        for (int k = 0; k < 3; k++) req_addr3[k*AW +: AW] = AW'(32'hB000 + k*32'h100 + cyc);
    endtask

    task automatic resp(input bit v, input logic [IW+SW-1:0] id, input bit last);
        mem_resp_valid = v;
        mem_resp_id    = id;
        mem_resp_last  = last;
        mem_resp_error = 1'b0;
        mem_resp_data  = $urandom;
    endtask

    logic [AW-1:0]    saved_addr;
    logic [IW+SW-1:0] saved_id;

    initial begin
        req_valid = '0; rsp_ready = '1; mem_req_ready = 1'b0;
        req_valid3 = '0; rsp_ready3 = '1; mem_req_ready3 = 1'b0;
        mem_resp_valid3 = 1'b0; mem_resp_id3 = '0;
        for (int k = 0; k < N; k++) req_id[k*IW +: IW] = IW'(k*5 + 1);
        for (int k = 0; k < 3; k++) req_id3[k*IW +: IW] = IW'(k*7 + 2);
        req_addr = '0; req_addr3 = '0;
        resp(1'b0, '0, 1'b0);
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset_unroutable3", 64'(unroutable3), 64'd0);

        // All channels valid, memory always ready: one grant per cycle in order 0,1,2,3,0
        rst = 1'b0; req_valid = 4'hF; mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_valid", 64'(mem_req_valid), 64'd1);
            chk("rr_sel", 64'(mem_req_id[IW +: SW]), 64'(i % 4));
        end

        // Backpressure with a full register
        mem_req_ready = 1'b0;
        saved_addr = mem_req_addr; saved_id = mem_req_id;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("stall_addr", 64'(mem_req_addr), 64'(saved_addr));
            chk("stall_id", 64'(mem_req_id), 64'(saved_id));
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        mem_req_ready = 1'b1; #1;
        chk("unstall_grant", 64'(req_ready), 64'b0010);
        tick();
        chk("unstall_sel", 64'(mem_req_id[IW +: SW]), 64'd1);

        // Saturate channel 2, others still served
        req_valid = 4'b0100;
        repeat (9) tick();
        #1 chk("ch2_blocked", 64'(req_ready[2]), 64'd0);
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ch2_blocked_others", 64'(req_ready), 64'(4'b1000 >> (i == 0 ? 0 : 4 - i)));
            tick();
        end
        req_valid = 4'b0100;
        resp(1'b1, {2'd2, 6'h05}, 1'b1);
        #1 chk("ch2_no_comb_path", 64'(req_ready), 64'd0);
        tick();
        resp(1'b0, '0, 1'b0);
        #1 chk("ch2_freed", 64'(req_ready), 64'b0100);
        tick();

        // Saturate channel 1, then a 4-beat response with one stall
        req_valid = 4'b0010;
        repeat (7) tick();
        #1 chk("ch1_blocked", 64'(req_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            resp(1'b1, {2'd1, 6'h2A}, c == 4);
            rsp_ready = (c == 1) ? 4'b1101 : 4'b1111;
            #1;
            chk("mb_rsp_valid", 64'(rsp_valid), 64'b0010);
            chk("mb_rsp_id", 64'(rsp_id), 64'h2A);
            chk("mb_data", 64'(rsp_data), 64'(mem_resp_data));
            chk("mb_mem_resp_ready", 64'(mem_resp_ready), (c == 1) ? 64'd0 : 64'd1);
            chk("mb_ch1_held", 64'(req_ready[1]), 64'd0);
            tick();
        end
        resp(1'b0, '0, 1'b0); rsp_ready = '1;
        #1 chk("mb_ch1_freed", 64'(req_ready[1]), 64'd1);
        req_valid = '0;
        tick();

        // Channel 3: grant and last-beat response in the same cycle
        req_valid = 4'b1000;
        repeat (8) tick();
        req_valid = '0;
        resp(1'b1, {2'd3, 6'h10}, 1'b1);
        tick();
        req_valid = 4'b1000;
        resp(1'b1, {2'd3, 6'h11}, 1'b1);
        #1 chk("ch3_simul_grant", 64'(req_ready), 64'b1000);
        tick();
        resp(1'b0, '0, 1'b0);
        #1 chk("ch3_after_simul", 64'(req_ready), 64'b1000);
        tick();
        #1 chk("ch3_full_again", 64'(req_ready), 64'd0);
        req_valid = '0;
        tick();
`ifdef HPDCACHE_MEM_RD_MUX_STATS_EN
        chk("stat_ch0", 64'(stat_grants[0 +: 32]), 64'd3);
        chk("stat_ch1", 64'(stat_grants[32 +: 32]), 64'd8);
        chk("stat_ch2", 64'(stat_grants[64 +: 32]), 64'd9);
        chk("stat_ch3", 64'(stat_grants[96 +: 32]), 64'd10);
`endif

        // N=3 instance: wrap-around order and unroutable select
        req_valid3 = 3'b111; mem_req_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n3_rr_sel", 64'(mem_req_id3[IW +: SW]), 64'(i % 3));
        end
        req_valid3 = '0;
        mem_resp_valid3 = 1'b1; mem_resp_id3 = {2'd3, 6'h15}; rsp_ready3 = 3'b000;
        #1;
        chk("n3_sink_ready", 64'(mem_resp_ready3), 64'd1);
        chk("n3_sink_no_valid", 64'(rsp_valid3), 64'd0);
        chk("n3_unr_before", 64'(unroutable3), 64'd0);
        tick();
        mem_resp_valid3 = 1'b0;
        #1 chk("n3_unr_set", 64'(unroutable3), 64'd1);
        tick();
        chk("n3_unr_sticky", 64'(unroutable3), 64'd1);
        mem_resp_valid3 = 1'b1; mem_resp_id3 = {2'd2, 6'h01}; rsp_ready3 = 3'b011;
        #1;
        chk("n3_route_valid", 64'(rsp_valid3), 64'b100);
        chk("n3_route_ready", 64'(mem_resp_ready3), 64'd0);
        chk("n3_route_id", 64'(rsp_id3), 64'h01);
        mem_resp_valid3 = 1'b0; rsp_ready3 = '1;
        tick();
`ifdef HPDCACHE_MEM_RD_MUX_STATS_EN
        chk("n3_stat_ch0", 64'(stat_grants3[0 +: 32]), 64'd2);
        chk("n3_stat_ch1", 64'(stat_grants3[32 +: 32]), 64'd1);
        chk("n3_stat_ch2", 64'(stat_grants3[64 +: 32]), 64'd1);
`else
        chk("n3_stat_zero", 64'(stat_grants3), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
